// File: rtl/rv_decode_pkg.sv
// RV64IM decode helpers shared by the issue path: major opcodes, operand-usage
// record and the instruction classifier.
package rv_decode_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic serialize;
  } operand_use_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } issue_state_t;

  function automatic operand_use_t classify(input logic [31:0] instr);
    operand_use_t u;
    u = '0;
    case (instr[6:0])
      OP, OP_32: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OP_IMM, OP_IMM_32, LOAD, JALR: begin
        u.use_rs1 = 1'b1;
        u.use_rd  = 1'b1;
      end
      STORE, BRANCH: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
      end
      LUI, AUIPC, JAL: begin
        u.use_rd = 1'b1;
      end
      SYSTEM: begin
        u.use_rs1   = 1'b1;
        u.use_rd    = 1'b1;
        u.serialize = 1'b1;
      end
      // Unknown opcodes travel down the pipe as operand-free bubbles.
      default: u = '0;
    endcase
    return u;
  endfunction

  function automatic logic writes_rd(input logic [31:0] instr);
    operand_use_t u;
    u = classify(instr);
    return u.use_rd;
  endfunction

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'h1 << idx;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with the
// retiring write bypassed into the hazard check in the same cycle.
module issue_scoreboard
  import rv_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        set_en_i,
  input  logic [4:0]  set_rd_i,
  input  logic        clr_en_i,
  input  logic [4:0]  clr_rd_i,
  input  logic        use_rs1_i,
  input  logic        use_rs2_i,
  input  logic        use_rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  output logic [31:0] busy_vec_o,
  output logic        hazard_o
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] wb_mask;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] busy_eff;
  logic        raw_rs1;
  logic        raw_rs2;
  logic        waw_rd;

  assign wb_mask  = wb_valid_i ? onehot32(wb_rd_i) : '0;
  assign set_mask = (set_en_i && (set_rd_i != 5'd0)) ? onehot32(set_rd_i) : '0;
  assign clr_mask = clr_en_i ? onehot32(clr_rd_i) : '0;
  assign busy_eff = busy_q & ~wb_mask;

  assign raw_rs1  = use_rs1_i && (rs1_i != 5'd0) && busy_eff[rs1_i];
  assign raw_rs2  = use_rs2_i && (rs2_i != 5'd0) && busy_eff[rs2_i];
  assign waw_rd   = use_rd_i  && (rd_i  != 5'd0) && busy_eff[rd_i];
  assign hazard_o = raw_rs1 || raw_rs2 || waw_rd;

  // A new claim on rd outranks a retiring write to the same register.
  always_comb begin
    busy_d = ((busy_q & ~wb_mask & ~clr_mask) | set_mask) & ~32'h1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue controller: scoreboard stall, in-flight cap, SYSTEM
// serialization and a single-entry issue register with valid/ready to execute.
module decode_issue_ctrl
  import rv_decode_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_npc,
  output logic             id_ready,
  output logic             iss_valid,
  output logic [31:0]      iss_instr,
  output logic [XLEN-1:0]  iss_npc,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_done,
  input  logic             flush,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int               INF_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);
  localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  operand_use_t     id_use;
  issue_state_t     state_q;
  issue_state_t     state_d;
  logic             iss_valid_q;
  logic             iss_valid_d;
  logic [31:0]      iss_instr_q;
  logic [31:0]      iss_instr_d;
  logic [XLEN-1:0]  iss_npc_q;
  logic [XLEN-1:0]  iss_npc_d;
  logic [INF_W-1:0] inflight_q;
  logic [INF_W-1:0] inflight_d;
  logic [INF_W-1:0] inflight_ret;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             reg_hazard;
  logic             cap_hazard;
  logic             hazard;
  logic             slot_free;
  logic             ser_block;
  logic             squash;
  logic             squash_clr;
  logic             ready_c;
  logic             accept;

  assign id_use = classify(id_instr);

  // The squashed instruction never reaches execute, so release its claim here.
  assign squash     = flush && iss_valid_q;
  assign squash_clr = squash && writes_rd(iss_instr_q);

  issue_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .set_en_i   (accept && id_use.use_rd),
    .set_rd_i   (id_instr[11:7]),
    .clr_en_i   (squash_clr),
    .clr_rd_i   (iss_instr_q[11:7]),
    .use_rs1_i  (id_use.use_rs1),
    .use_rs2_i  (id_use.use_rs2),
    .use_rd_i   (id_use.use_rd),
    .rs1_i      (id_instr[19:15]),
    .rs2_i      (id_instr[24:20]),
    .rd_i       (id_instr[11:7]),
    .busy_vec_o (busy_vec),
    .hazard_o   (reg_hazard)
  );

  assign cap_hazard = (inflight_q == INF_MAX) && !wb_done;
  assign hazard     = reg_hazard || cap_hazard;
  assign slot_free  = !iss_valid_q || ex_ready;
  assign ser_block  = id_use.serialize && ((inflight_q != '0) || (busy_vec != '0));

  // Retirements only; kept apart from accept so the drain test has no comb loop.
  always_comb begin
    inflight_ret = inflight_q;
    if (wb_done && (inflight_ret != '0)) begin
      inflight_ret = inflight_ret - INF_ONE;
    end
    if (squash && (inflight_ret != '0)) begin
      inflight_ret = inflight_ret - INF_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      RUN: begin
        ready_c = !reset && slot_free && !hazard && !ser_block && !flush;
        if (id_valid && ready_c && id_use.serialize) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_ret == '0) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign accept     = id_valid && ready_c;
  assign inflight_d = accept ? (inflight_ret + INF_ONE) : inflight_ret;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_instr_d = iss_instr_q;
    iss_npc_d   = iss_npc_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d = 1'b1;
      iss_instr_d = id_instr;
      iss_npc_d   = id_npc;
    end else if (ex_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !ready_c && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_instr_q <= '0;
      iss_npc_q   <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_instr_q <= iss_instr_d;
      iss_npc_q   <= iss_npc_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_ready  = ready_c;
  assign iss_valid = iss_valid_q;
  assign iss_instr = iss_instr_q;
  assign iss_npc   = iss_npc_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: stimulus queues expected issues, a
// monitor checks each issue handshake against that queue.
module tb_decode_issue_ctrl;
  import rv_decode_pkg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  localparam logic [31:0] ADDI5  = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] ADD6   = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] LUI10  = 32'h0000_0537; // lui  x10,0
  localparam logic [31:0] LUI11  = 32'h0000_05B7;
  localparam logic [31:0] LUI12  = 32'h0000_0637;
  localparam logic [31:0] LUI13  = 32'h0000_06B7;
  localparam logic [31:0] LUI2   = 32'h0000_0137;
  localparam logic [31:0] CSRW7  = 32'h3400_13F3; // csrrw x7,mscratch,x0
  localparam logic [31:0] SW32   = 32'h0031_2023; // sw   x3,0(x2)
  localparam logic [31:0] ADDI9  = 32'h0010_0493; // addi x9,x0,1
  localparam logic [31:0] ADD4   = 32'h0020_8233; // add  x4,x1,x2

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [XLEN-1:0]  id_npc;
  logic             id_ready;
  logic             iss_valid;
  logic [31:0]      iss_instr;
  logic [XLEN-1:0]  iss_npc;
  logic             ex_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_done;
  logic             flush;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0]     exp_instr_q[$];
  logic [XLEN-1:0] exp_npc_q[$];

  always #5 clk = ~clk;

  decode_issue_ctrl #(
    .XLEN         (XLEN),
    .MAX_INFLIGHT (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_npc    (id_npc),
    .id_ready  (id_ready),
    .iss_valid (iss_valid),
    .iss_instr (iss_instr),
    .iss_npc   (iss_npc),
    .ex_ready  (ex_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_done   (wb_done),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [XLEN-1:0] npc);
    id_valid = 1'b1;
    id_instr = ins;
    id_npc   = npc;
  endtask

  task automatic expect_issue(input logic [31:0] ins, input logic [XLEN-1:0] npc);
    exp_instr_q.push_back(ins);
    exp_npc_q.push_back(npc);
  endtask

  // Monitor: every issue handshake must match the next queued instruction.
  initial begin
    logic [31:0]     ei;
    logic [XLEN-1:0] en;
    forever begin
      @(negedge clk);
      if (!reset && iss_valid && ex_ready && !flush) begin
        if (exp_instr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got=%0h want=none", iss_instr);
        end else begin
          ei = exp_instr_q.pop_front();
          en = exp_npc_q.pop_front();
          chk("iss_instr", 64'(iss_instr), 64'(ei));
          chk("iss_npc", iss_npc, en);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_instr = '0; id_npc = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_done = 1'b0; flush = 1'b0;
    cyc(); cyc();
    settle(); chk("rst_id_ready", 64'(id_ready), 64'd0);
    reset = 1'b0;
    settle();
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_instr", 64'(iss_instr), 64'd0);
    chk("rst_iss_npc", iss_npc, 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);

    // RAW on x5, resolved by a same-cycle writeback bypass
    cyc(); offer(ADDI5, 64'h1000); settle();
    chk("t1_addi_ready", 64'(id_ready), 64'd1); expect_issue(ADDI5, 64'h1000);
    cyc(); offer(ADD6, 64'h1004); settle();
    chk("t1_busy_x5", 64'(busy_vec), 64'h20);
    chk("t1_iss_valid", 64'(iss_valid), 64'd1);
    chk("t1_add_stall", 64'(id_ready), 64'd0);
    cyc(); settle();
    chk("t1_stall_cnt1", 64'(stall_cnt), 64'd1);
    chk("t1_add_stall2", 64'(id_ready), 64'd0);
    cyc(); wb_valid = 1'b1; wb_rd = 5'd5; settle();
    chk("t1_bypass_ready", 64'(id_ready), 64'd1);
    chk("t1_stall_cnt2", 64'(stall_cnt), 64'd2);
    expect_issue(ADD6, 64'h1004);
    cyc(); id_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; wb_done = 1'b1; settle();
    chk("t1_busy_x6", 64'(busy_vec), 64'h40);
    chk("t1_inflight2", 64'(dut.inflight_q), 64'd2);
    cyc(); wb_valid = 1'b0; settle();
    chk("t1_inflight1", 64'(dut.inflight_q), 64'd1);
    cyc(); wb_done = 1'b0; settle();
    chk("t1_inflight0", 64'(dut.inflight_q), 64'd0);
    chk("t1_busy_clear", 64'(busy_vec), 64'd0);

    // In-flight cap: four lui fill the window, a fifth waits for wb_done
    for (int i = 1; i <= 4; i++) begin
      cyc(); offer(32'(i << 7) | 32'h37, 64'h2000 + 64'(4 * i)); settle();
      chk("t2_lui_ready", 64'(id_ready), 64'd1);
      expect_issue(32'(i << 7) | 32'h37, 64'h2000 + 64'(4 * i));
    end
    cyc(); offer(LUI10, 64'h2020); settle();
    chk("t2_fifth_stall", 64'(id_ready), 64'd0);
    chk("t2_inflight_full", 64'(dut.inflight_q), 64'd4);
    cyc(); wb_done = 1'b1; settle();
    chk("t2_fifth_ready", 64'(id_ready), 64'd1);
    expect_issue(LUI10, 64'h2020);
    cyc(); id_valid = 1'b0; wb_done = 1'b0; settle();
    chk("t2_inflight_stays4", 64'(dut.inflight_q), 64'd4);
    chk("t2_busy", 64'(busy_vec), 64'h41E);
    chk("t2_stall_cnt", 64'(stall_cnt), 64'd3);
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1; wb_rd = (i < 4) ? 5'(i + 1) : 5'd10; wb_done = 1'b1;
      cyc();
    end
    wb_valid = 1'b0; wb_done = 1'b0; settle();
    chk("t2_drained_busy", 64'(busy_vec), 64'd0);
    chk("t2_drained_inflight", 64'(dut.inflight_q), 64'd0);

    // SYSTEM serialization
    cyc(); offer(LUI11, 64'h3000); settle();
    chk("t3_lui11_ready", 64'(id_ready), 64'd1); expect_issue(LUI11, 64'h3000);
    cyc(); offer(LUI12, 64'h3004); settle();
    chk("t3_lui12_ready", 64'(id_ready), 64'd1); expect_issue(LUI12, 64'h3004);
    cyc(); offer(CSRW7, 64'h3008); settle();
    chk("t3_csr_wait2", 64'(id_ready), 64'd0);
    chk("t3_inflight2", 64'(dut.inflight_q), 64'd2);
    cyc(); wb_valid = 1'b1; wb_rd = 5'd11; wb_done = 1'b1; settle();
    chk("t3_csr_wait2b", 64'(id_ready), 64'd0);
    cyc(); wb_rd = 5'd12; settle();
    chk("t3_csr_wait1", 64'(id_ready), 64'd0);
    cyc(); wb_valid = 1'b0; wb_done = 1'b0; settle();
    chk("t3_csr_ready", 64'(id_ready), 64'd1);
    expect_issue(CSRW7, 64'h3008);
    cyc(); offer(LUI13, 64'h300C); settle();
    chk("t3_state_drain", 64'(dut.state_q), 64'(DRAIN));
    chk("t3_busy_x7", 64'(busy_vec), 64'h80);
    chk("t3_drain_stall", 64'(id_ready), 64'd0);
    cyc(); wb_valid = 1'b1; wb_rd = 5'd7; wb_done = 1'b1; settle();
    chk("t3_drain_stall2", 64'(id_ready), 64'd0);
    cyc(); wb_valid = 1'b0; wb_done = 1'b0; settle();
    chk("t3_state_run", 64'(dut.state_q), 64'(RUN));
    chk("t3_after_csr_ready", 64'(id_ready), 64'd1);
    expect_issue(LUI13, 64'h300C);
    cyc(); id_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd13; wb_done = 1'b1; settle();
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd8);
    chk("t3_busy_x13", 64'(busy_vec), 64'h2000);
    cyc(); wb_valid = 1'b0; wb_done = 1'b0; settle();
    chk("t3_idle_busy", 64'(busy_vec), 64'd0);

    // Store: RAW on base register, never claims a destination
    cyc(); offer(LUI2, 64'h4000); settle();
    chk("t4_lui2_ready", 64'(id_ready), 64'd1); expect_issue(LUI2, 64'h4000);
    cyc(); offer(SW32, 64'h4004); settle();
    chk("t4_busy_x2", 64'(busy_vec), 64'h4);
    chk("t4_sw_stall", 64'(id_ready), 64'd0);
    cyc(); wb_valid = 1'b1; wb_rd = 5'd2; wb_done = 1'b1; settle();
    chk("t4_sw_ready", 64'(id_ready), 64'd1); expect_issue(SW32, 64'h4004);
    cyc(); id_valid = 1'b0; wb_valid = 1'b0; wb_done = 1'b0; settle();
    chk("t4_sw_no_busy", 64'(busy_vec), 64'd0);
    chk("t4_inflight1", 64'(dut.inflight_q), 64'd1);
    cyc(); wb_done = 1'b1;
    cyc(); wb_done = 1'b0; settle();
    chk("t4_inflight0", 64'(dut.inflight_q), 64'd0);

    // Flush: blocks a same-cycle accept, and squashes a held instruction
    cyc(); offer(ADDI9, 64'h5000); flush = 1'b1; settle();
    chk("t5_flush_blocks", 64'(id_ready), 64'd0);
    cyc(); id_valid = 1'b0; flush = 1'b0; settle();
    chk("t5_iss_valid", 64'(iss_valid), 64'd0);
    chk("t5_busy_x9", 64'(busy_vec[9]), 64'd0);
    chk("t5_inflight", 64'(dut.inflight_q), 64'd0);
    chk("t5_stall_cnt", 64'(stall_cnt), 64'd10);
    cyc(); ex_ready = 1'b0; offer(ADDI9, 64'h5004); settle();
    chk("t5_addi9_ready", 64'(id_ready), 64'd1);
    cyc(); id_valid = 1'b0; flush = 1'b1; settle();
    chk("t5_held", 64'(iss_valid), 64'd1);
    chk("t5_held_busy", 64'(busy_vec), 64'h200);
    cyc(); flush = 1'b0; ex_ready = 1'b1; settle();
    chk("t5_squashed", 64'(iss_valid), 64'd0);
    chk("t5_squash_busy", 64'(busy_vec), 64'd0);
    chk("t5_squash_inflight", 64'(dut.inflight_q), 64'd0);

    // Reset in the middle of a stall
    for (int i = 1; i <= 3; i++) begin
      cyc(); offer(32'(i << 7) | 32'h37, 64'h6000 + 64'(4 * i)); settle();
      chk("t6_lui_ready", 64'(id_ready), 64'd1);
      expect_issue(32'(i << 7) | 32'h37, 64'h6000 + 64'(4 * i));
    end
    cyc(); offer(ADD4, 64'h6010); settle();
    chk("t6_add_stall", 64'(id_ready), 64'd0);
    chk("t6_busy", 64'(busy_vec), 64'hE);
    chk("t6_inflight3", 64'(dut.inflight_q), 64'd3);
    cyc(); reset = 1'b1; settle();
    chk("t6_ready_in_reset", 64'(id_ready), 64'd0);
    cyc(); reset = 1'b0; settle();
    chk("t6_iss_valid", 64'(iss_valid), 64'd0);
    chk("t6_iss_instr", 64'(iss_instr), 64'd0);
    chk("t6_iss_npc", iss_npc, 64'd0);
    chk("t6_busy_zero", 64'(busy_vec), 64'd0);
    chk("t6_stall_zero", 64'(stall_cnt), 64'd0);
    chk("t6_inflight_zero", 64'(dut.inflight_q), 64'd0);
    chk("t6_state_run", 64'(dut.state_q), 64'(RUN));
    chk("t6_post_reset_ready", 64'(id_ready), 64'd1);
    expect_issue(ADD4, 64'h6010);
    cyc(); id_valid = 1'b0; settle();
    chk("t6_add_issued", 64'(iss_valid), 64'd1);
    chk("t6_busy_x4", 64'(busy_vec), 64'h10);
    cyc(); cyc(); settle();
    chk("queue_drained", 64'(exp_instr_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
